// File: rtl/lsu_mem_access_pkg.sv
// ---------------------------------------------------------------------------
// lsu_mem_access_pkg
// Shared definitions for the memory-stage load/store unit:
//   - RV32I funct3 codes for loads and stores
//   - LSU FSM state encoding
//   - small helpers for request legality and store lane formatting
// ---------------------------------------------------------------------------
package lsu_mem_access_pkg;

    // Load funct3 codes
    localparam logic [2:0] INST_LB  = 3'b000;
    localparam logic [2:0] INST_LH  = 3'b001;
    localparam logic [2:0] INST_LW  = 3'b010;
    localparam logic [2:0] INST_LBU = 3'b100;
    localparam logic [2:0] INST_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] INST_SB  = 3'b000;
    localparam logic [2:0] INST_SH  = 3'b001;
    localparam logic [2:0] INST_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_e;

    // Stores accept only the three signed-width codes; loads add BU/HU.
    function automatic logic funct3_ok(input logic [2:0] f3, input logic is_store);
        if (is_store) begin
            return f3 inside {INST_SB, INST_SH, INST_SW};
        end
        return f3 inside {INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU};
    endfunction

    // size = funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b01:   return ~lane[0];
            2'b10:   return (lane == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the store data across lanes lets the slave pick any lane
    // using only the byte enables.
    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] sd);
        case (size)
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_access_if
// req/ack data bus between the LSU (master) and data RAM / MMIO (slave).
//   bus_req   : access request, held until the cycle after bus_ack
//   bus_we    : 1 = write
//   bus_addr  : word address ([1:0] always 00)
//   bus_wdata : lane-replicated store data
//   bus_be    : byte enables
//   bus_ack   : access complete; bus_rdata valid in the same cycle
//   bus_rdata : read word
// ---------------------------------------------------------------------------
interface lsu_mem_access_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
// Combinational load formatter: selects the addressed byte/half of a read
// word and sign- or zero-extends it according to funct3. Shared with the
// MMIO read path.
//   rdata_i  : 32-bit read word from the bus
//   lane_i   : byte offset of the access (addr[1:0])
//   funct3_i : load width/sign code
//   data_o   : formatted 32-bit load result
// ---------------------------------------------------------------------------
module lsu_load_align
    import lsu_mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata_i[{lane_i, 3'b000} +: 8];
    assign half_v = rdata_i[{lane_i[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: default first so every path assigns data_o and no latch is inferred.
        data_o = rdata_i;
        case (funct3_i)
            INST_LB:  data_o = {{24{byte_v[7]}}, byte_v};
            INST_LBU: data_o = {24'h0, byte_v};
            INST_LH:  data_o = {{16{half_v[15]}}, half_v};
            INST_LHU: data_o = {16'h0, half_v};
            default:  data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// ---------------------------------------------------------------------------
// lsu_mem_access
// Memory-stage load/store unit of the RV32I pipeline. Turns a MEM-stage
// load/store into one req/ack bus transaction, stalls the pipeline until it
// completes, and formats load data for write-back.
//   clk, rst_n            : core clock, synchronous active-low reset
//   mem_read, mem_write   : MEM-stage load / store
//   funct3                : width/sign code
//   addr, store_data      : effective address, rs2 value
//   stall                 : freeze IF..MEM
//   load_data, load_valid : formatted load result and its one-cycle strobe
//   fault                 : one-cycle pulse on illegal request or timeout
//   bus                   : master side of the data bus
// ---------------------------------------------------------------------------
module lsu_mem_access
    import lsu_mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              fault,
    lsu_mem_access_if.master  bus
);

    localparam int unsigned           CNT_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]      TIMEOUT_MAX = CNT_W'(TIMEOUT_CYC);

    lsu_state_e        state_q;
    logic              req_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [31:0]       load_data_q;
    logic              load_valid_q;
    logic              fault_q;
    logic [31:0]       load_fmt;
    logic              legal;

    // A request is exactly one of read/write with a valid, aligned width.
    assign legal = (mem_read ^ mem_write)
                 && funct3_ok(funct3, mem_write)
                 && is_aligned(funct3[1:0], addr[1:0]);

    // Stall is combinational in the accepting IDLE cycle so the instruction
    // cannot leave MEM before its access has been registered.
    assign stall = (state_q == ST_ACCESS) || ((state_q == ST_IDLE) && legal);
    assign cnt_d = cnt_q + CNT_W'(1);

    lsu_load_align u_load_align (
        .rdata_i  (bus.bus_rdata),
        .lane_i   (lane_q),
        .funct3_i (f3_q),
        .data_o   (load_fmt)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout so every register samples
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            f3_q         <= '0;
            lane_q       <= '0;
            cnt_q        <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (legal) begin
                        addr_q  <= {addr[31:2], 2'b00};
                        we_q    <= mem_write;
                        be_q    <= byte_mask(funct3[1:0], addr[1:0]);
                        wdata_q <= lane_replicate(funct3[1:0], store_data);
                        f3_q    <= funct3;
                        lane_q  <= addr[1:0];
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        state_q <= ST_ACCESS;
                    end else if (mem_read || mem_write) begin
                        fault_q <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    // An ack arriving on the last allowed cycle still wins.
                    if (bus.bus_ack) begin
                        req_q <= 1'b0;
                        if (!we_q) begin
                            load_data_q  <= load_fmt;
                            load_valid_q <= 1'b1;
                        end
                        state_q <= ST_DONE;
                    end else if (cnt_d == TIMEOUT_MAX) begin
                        req_q       <= 1'b0;
                        load_data_q <= '0;
                        fault_q     <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_be    = be_q;
    assign load_data     = load_data_q;
    assign load_valid    = load_valid_q;
    assign fault         = fault_q;

endmodule
